// File: rtl/pe_array_seq.sv
// rtl/pe_array_seq.sv - sequential processing-element array computing per-channel dot-product sums
module pe_array_seq #(
  parameter int ARRAY_M      = 8,
  parameter int ARRAY_N      = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int FILTER_WIDTH = 8,
  parameter int ACCU_WIDTH   = 24,
  parameter int NUM_DATA     = 16,
  parameter int SATURATE     = 1,
  localparam int KW = $clog2(ARRAY_N + 1),
  localparam int DNW = $clog2(NUM_DATA + 1),
  localparam int RW = (ARRAY_M > 1) ? $clog2(ARRAY_M) : 1,
  localparam int CW = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [KW-1:0]                    cfg_num_kernel,
  input  logic [DNW-1:0]                   cfg_num_data,
  input  logic                             filt_valid,
  output logic                             filt_ready,
  input  logic [RW-1:0]                    filt_row,
  input  logic [CW-1:0]                    filt_col,
  input  logic [NUM_DATA*FILTER_WIDTH-1:0] filt_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_DATA*DATA_WIDTH-1:0]   in_data,
  output logic                             busy,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ARRAY_M*ACCU_WIDTH-1:0]    out_data
);

  localparam int PW = FILTER_WIDTH + DATA_WIDTH + $clog2(NUM_DATA);
  localparam int SW = PW + $clog2(ARRAY_N);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_REDUCE  = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  logic [2:0] state;
  logic [KW-1:0] k_q, beat_q, k_eff;
  logic [DNW-1:0] d_q, tap_q, d_eff;
  logic [ARRAY_M*ACCU_WIDTH-1:0] out_data_q;

  logic signed [FILTER_WIDTH-1:0] filt_q [ARRAY_M][ARRAY_N][NUM_DATA];
  logic signed [DATA_WIDTH-1:0]   in_q   [ARRAY_N][NUM_DATA];
  logic signed [PW-1:0]           acc_q  [ARRAY_M][ARRAY_N];
  logic signed [FILTER_WIDTH-1:0] f_tap  [ARRAY_M][ARRAY_N];
  logic signed [DATA_WIDTH-1:0]   x_tap  [ARRAY_N];
  logic signed [SW-1:0]           sum_c  [ARRAY_M];
  logic [ACCU_WIDTH-1:0]          conv   [ARRAY_M];

  assign filt_ready = (state == S_IDLE);
  assign in_ready   = (state == S_LOAD);
  assign busy       = (state != S_IDLE);
  assign out_valid  = (state == S_OUTPUT);
  assign out_data   = out_data_q;

  // Out-of-range or zero configuration falls back to the full array size.
  assign k_eff = (cfg_num_kernel == '0 || cfg_num_kernel > KW'(ARRAY_N)) ? KW'(ARRAY_N) : cfg_num_kernel;
  assign d_eff = (cfg_num_data == '0 || cfg_num_data > DNW'(NUM_DATA)) ? DNW'(NUM_DATA) : cfg_num_data;

  // Filter storage: written only while idle, persists across passes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int m = 0; m < ARRAY_M; m++)
        for (int n = 0; n < ARRAY_N; n++)
          for (int t = 0; t < NUM_DATA; t++)
            filt_q[m][n][t] <= '0;
    end else if (state == S_IDLE && filt_valid) begin
      for (int m = 0; m < ARRAY_M; m++)
        for (int n = 0; n < ARRAY_N; n++)
          if (filt_row == RW'(m) && filt_col == CW'(n))
            for (int t = 0; t < NUM_DATA; t++)
              filt_q[m][n][t] <= filt_data[t*FILTER_WIDTH +: FILTER_WIDTH];
    end
  end

  // Input column registers: beat j lands in column j, shared by every row.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < ARRAY_N; n++)
        for (int t = 0; t < NUM_DATA; t++)
          in_q[n][t] <= '0;
    end else if (state == S_LOAD && in_valid) begin
      for (int n = 0; n < ARRAY_N; n++)
        if (beat_q == KW'(n))
          for (int t = 0; t < NUM_DATA; t++)
            in_q[n][t] <= in_data[t*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Select the current tap of every filter and input vector.
  always_comb begin
    for (int n = 0; n < ARRAY_N; n++) begin
      x_tap[n] = '0;
      for (int t = 0; t < NUM_DATA; t++)
        if (tap_q == DNW'(t)) x_tap[n] = in_q[n][t];
    end
    for (int m = 0; m < ARRAY_M; m++)
      for (int n = 0; n < ARRAY_N; n++) begin
        f_tap[m][n] = '0;
        for (int t = 0; t < NUM_DATA; t++)
          if (tap_q == DNW'(t)) f_tap[m][n] = filt_q[m][n][t];
      end
  end

  // Accumulators: held at zero during LOAD so COMPUTE always starts clean.
  always_ff @(posedge clk) begin
    if (reset || state == S_LOAD) begin
      for (int m = 0; m < ARRAY_M; m++)
        for (int n = 0; n < ARRAY_N; n++)
          acc_q[m][n] <= '0;
    end else if (state == S_COMPUTE) begin
      for (int m = 0; m < ARRAY_M; m++)
        for (int n = 0; n < ARRAY_N; n++)
          acc_q[m][n] <= acc_q[m][n] + PW'(f_tap[m][n]) * PW'(x_tap[n]);
    end
  end

  // Row reduction over the active columns only.
  always_comb begin
    for (int m = 0; m < ARRAY_M; m++) begin
      sum_c[m] = '0;
      for (int n = 0; n < ARRAY_N; n++)
        if (KW'(n) < k_q) sum_c[m] = sum_c[m] + SW'(acc_q[m][n]);
    end
  end

  generate
    if (SW > ACCU_WIDTH) begin : g_narrow
      localparam logic signed [SW-1:0] MAXV = {{(SW-ACCU_WIDTH+1){1'b0}}, {(ACCU_WIDTH-1){1'b1}}};
      localparam logic signed [SW-1:0] MINV = ~MAXV;
      // Clamp or wrap the full-precision sum into the output width.
      always_comb begin
        for (int m = 0; m < ARRAY_M; m++) begin
          if (SATURATE != 0 && sum_c[m] > MAXV)      conv[m] = MAXV[ACCU_WIDTH-1:0];
          else if (SATURATE != 0 && sum_c[m] < MINV) conv[m] = MINV[ACCU_WIDTH-1:0];
          else                                       conv[m] = sum_c[m][ACCU_WIDTH-1:0];
        end
      end
    end else begin : g_wide
      // Output is at least as wide as the sum: plain sign extension.
      always_comb begin
        for (int m = 0; m < ARRAY_M; m++)
          conv[m] = ACCU_WIDTH'(sum_c[m]);
      end
    end
  endgenerate

  // Control FSM with beat/tap counters and the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      k_q        <= '0;
      d_q        <= '0;
      beat_q     <= '0;
      tap_q      <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          k_q    <= k_eff;
          d_q    <= d_eff;
          beat_q <= '0;
          state  <= S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          if (beat_q == k_q - KW'(1)) begin
            beat_q <= '0;
            tap_q  <= '0;
            state  <= S_COMPUTE;
          end else begin
            beat_q <= beat_q + KW'(1);
          end
        end
        S_COMPUTE: begin
          tap_q <= tap_q + DNW'(1);
          if (tap_q == d_q - DNW'(1)) state <= S_REDUCE;
        end
        S_REDUCE: begin
          for (int m = 0; m < ARRAY_M; m++)
            out_data_q[m*ACCU_WIDTH +: ACCU_WIDTH] <= conv[m];
          state <= S_OUTPUT;
        end
        S_OUTPUT: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pe_array_seq.md
PE_ARRAY_SEQ -- requirements
Module: pe_array_seq

Interface
REQ-001 Parameter ARRAY_M, default 8, output channels (rows).
REQ-002 Parameter ARRAY_N, default 8, kernels per row (columns).
REQ-003 Parameters DATA_WIDTH and FILTER_WIDTH, default 8 each; signed two's-complement operands.
REQ-004 Parameter ACCU_WIDTH, default 24, signed output width per channel.
REQ-005 Parameter NUM_DATA, default 16, taps per input and filter vector.
REQ-006 Parameter SATURATE, default 1; 1 clamps the output, 0 wraps it.
REQ-007 Clock and reset are fixed: one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-008 Port clk, input, 1, clock; all state changes on its rising edge.
REQ-009 Port reset, input, 1, synchronous active-high reset.
REQ-010 Port start, input, 1, begins one convolution pass when sampled in IDLE.
REQ-011 Port cfg_num_kernel, input, clog2(ARRAY_N+1), active columns K, captured with start.
REQ-012 Port cfg_num_data, input, clog2(NUM_DATA+1), active taps D, captured with start.
REQ-013 Port filt_valid, input, 1, filter write strobe.
REQ-014 Port filt_ready, output, 1, high only in IDLE.
REQ-015 Ports filt_row (clog2(ARRAY_M)) and filt_col (clog2(ARRAY_N)), inputs, select the target PE.
REQ-016 Port filt_data, input, NUM_DATA*FILTER_WIDTH, filter vector; tap t is at bits [t*FILTER_WIDTH +: FILTER_WIDTH].
REQ-017 Ports in_valid (input, 1) and in_ready (output, 1), input-vector handshake.
REQ-018 Port in_data, input, NUM_DATA*DATA_WIDTH, input vector with the same tap packing as filt_data.
REQ-019 Port busy, output, 1, high in every state except IDLE.
REQ-020 Ports out_valid (output, 1) and out_ready (input, 1), result handshake.
REQ-021 Port out_data, output, ARRAY_M*ACCU_WIDTH; channel m is at bits [m*ACCU_WIDTH +: ACCU_WIDTH].

Function
REQ-022 FSM states: IDLE, LOAD, COMPUTE, REDUCE, OUTPUT.
REQ-023 IDLE: filt_valid writes filt_data into PE(filt_row, filt_col); start moves the FSM to LOAD and captures K and D; a write and start in the same cycle both take effect.
REQ-024 Capture rules: K=0 or K>ARRAY_N is treated as ARRAY_N; D=0 or D>NUM_DATA is treated as NUM_DATA.
REQ-025 LOAD: in_ready=1; accepted beat j (0..K-1) is stored in column j input register, shared by all rows; after beat K-1 the FSM moves to COMPUTE.
REQ-026 COMPUTE: all PE accumulators are cleared on entry; over D cycles, cycle t does acc[m][n] += filter[m][n][t]*input[n][t] (signed); then the FSM moves to REDUCE.
REQ-027 PE accumulator width is FILTER_WIDTH+DATA_WIDTH+clog2(NUM_DATA); it never overflows.
REQ-028 REDUCE, 1 cycle: sum[m] = sum of acc[m][n] for n<K, at full precision plus clog2(ARRAY_N) bits; columns n>=K contribute 0.
REQ-029 Output conversion: SATURATE=1 clamps to [-2^(ACCU_WIDTH-1), 2^(ACCU_WIDTH-1)-1]; SATURATE=0 keeps the low ACCU_WIDTH bits; the result is registered into out_data.
REQ-030 OUTPUT: out_valid=1; out_data is held stable until out_valid&&out_ready, then the FSM returns to IDLE and out_valid drops in the next cycle.
REQ-031 Latency: with in_valid held high, out_valid is first high K+D+1 rising edges after the edge that samples start.
REQ-032 start outside IDLE is ignored; in_valid outside LOAD is ignored (in_ready=0); filt_valid outside IDLE is ignored.
REQ-033 Filter registers persist across passes until rewritten or reset.

Reset
REQ-034 reset in any state, mid-pass included, forces IDLE next cycle and clears filters, inputs, accumulators, counters, K and D.
REQ-035 Reset values: out_valid=0, out_data=0, in_ready=0, busy=0, filt_ready=1 in the cycle after reset deasserts.

Verification
REQ-036 Defaults; all filters 1; K=8, D=16; 8 input beats with all taps 2 -> every channel 256, out_valid at edge 25 after start.
REQ-037 K=3, D=4; columns 3..7 loaded with nonzero filters and inputs -> output equals the 3-column, 4-tap reference model exactly.
REQ-038 ACCU_WIDTH=16, filters 127, inputs 127, K=8, D=16: SATURATE=1 -> 32767; filters -128 -> -32768; SATURATE=0 with filters 127 -> 0x8080.
REQ-039 out_ready held low 5 cycles in OUTPUT -> out_data stable, out_valid=1, in_ready=0, start ignored; transfer completes on the first out_ready=1 edge.
REQ-040 Gaps in in_valid during LOAD: out_valid is delayed by exactly the number of stall cycles and the result is unchanged.
REQ-041 reset asserted at COMPUTE cycle 7 -> IDLE next cycle, all outputs at reset values; the following pass after reloading filters gives correct results.
